disp_sched: RTL and testbench
=============================

# disp_sched

Display scheduler for the shared six-digit seven-segment driver. It time-shares the driver's data/control inputs between NSRC display sources, such as the clock and the traffic counters. It supports three modes: automatic rotation on a 1 Hz tick, manual stepping by push-button, and a priority override for sources raising an alert. It replaces the static source-select mux in front of `seg_driver`.

## Interface
- `NSRC`, 3: number of sources; legal range 2..8.
- `DWELL`, 5: ticks spent on each source in auto mode; legal range 1..255.
- `DIGITS`, 6: digits per source frame.
- `DB_CYCLES`, 1_000_000: debounce stable-time in `clk` cycles; used only with the debounce feature.
- `clk`  in  1  system clock; the block has one clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle pulse, 1 Hz, synchronous to `clk`.
- `btn`  in  1  raw "next source" button; asynchronous, active-high.
- `auto_en`  in  1  1 = auto rotation, 0 = manual.
- `req`  in  NSRC  per-source override request, level-sensitive.
- `src_data`  in  NSRC*DIGITS*8  source frames; source i occupies bits [i*DIGITS*8 +: DIGITS*8].
- `src_ctl`  in  NSRC*DIGITS  per-source digit enables.
- `seg_data`  out  DIGITS*8  frame to `seg_driver`.
- `seg_ctl`  out  DIGITS  digit enables to `seg_driver`.
- `cur_src`  out  clog2(NSRC)  index of the selected source.
- `switched`  out  1  one-cycle pulse whenever `cur_src` changes.

## Operation
- **Reset values:** `cur_src`=0, `seg_data`=0, `seg_ctl`=0 (all digits dark), `switched`=0, state=MANUAL, dwell counter=0, saved source=0.
- **States:**
  - AUTO: dwell counter advances on each `tick`. On a `tick` with counter = DWELL-1, `cur_src` = (`cur_src`+1) mod NSRC and the counter clears. The wrap NSRC-1 -> 0 is required.
  - MANUAL: the counter is held at 0. Only a button event advances `cur_src`.
  - OVR: entered from AUTO or MANUAL when `req` != 0.
    - On entry, `cur_src` is saved, and `cur_src` becomes the lowest-index set bit of `req`.
    - While in OVR, `cur_src` tracks the lowest set `req` bit every cycle. The dwell counter is frozen, and `tick` and button events are ignored (button events are dropped, not queued).
    - When `req`=0, the block restores the saved source and goes to AUTO if `auto_en`, else MANUAL. The counter clears on exit.
- **`auto_en` transitions:**
  - AUTO <-> MANUAL follows `auto_en`, one cycle after it changes.
  - Entry to AUTO clears the counter.
  - An `auto_en` change while in OVR only selects the exit state.
- **Button event:** debounced rising edge of `btn`, one cycle wide. In AUTO or MANUAL it advances `cur_src` by 1 mod NSRC and clears the counter.
- **Simultaneous events:**
  - `req` != 0 beats button and `tick`.
  - Button beats `tick`: advance by exactly 1, counter cleared.
- **Out-of-range index:** `cur_src` never reaches NSRC or above. `req` bits are only examined for indices below NSRC.
- **Output frame:** `seg_data`/`seg_ctl` are registered copies of `src_data`/`src_ctl` slice `cur_src`. They are refreshed every cycle, so source content changes pass through live.

## Timing
- Event (`tick`, button pulse, `req` edge) in cycle N -> `cur_src` and `switched` in cycle N+1 -> `seg_data`/`seg_ctl` in cycle N+2.
- Raw `btn` -> button event: 2-FF synchroniser plus edge detect = 3 cycles, plus DB_CYCLES when debounce is on.
- `rstn` assertion mid-operation clears all state immediately; the next frame appears 2 cycles after deassertion.

## Configuration
- `DISP_SCHED_DEBOUNCE_EN` defined: the synchronised `btn` must stay stable for DB_CYCLES consecutive cycles before its level is accepted. A glitch resets the stability count.
- Not defined: the synchronised `btn` goes directly to edge detect, and DB_CYCLES is unused. This is for simulation and for boards with hardware-debounced buttons.

## Structure
- Package `disp_sched_pkg`: state typedef `disp_state_t` {ST_AUTO, ST_MANUAL, ST_OVR}, and default constant `DB_CYCLES_DEF`.
- Sub-module `btn_debounce`: synchroniser, optional debounce counter and rising-edge pulse generator. The FSM, dwell counter, priority encoder and output registers stay in `disp_sched`.

## Test plan
- Reset, `auto_en`=1, NSRC=3, DWELL=2, 7 ticks -> `cur_src` sequence 0,1,2,0 after ticks 2,4,6. `switched` pulses three times. Frame follows 1 cycle behind.
- `auto_en`=0, ticks applied -> `cur_src` stays 0. Button press (debounce off) -> `cur_src`=1 four cycles after the `btn` rise.
- In AUTO on source 1: `req`=3'b110 -> `cur_src`=1. Then `req`=3'b100 -> 2. Then `req`=0 -> restored to 1, dwell counter=0.
- `tick` and button event in the same cycle -> `cur_src` advances by exactly 1. Button during OVR -> ignored, no change after `req` clears beyond the restore.
- With `DISP_SCHED_DEBOUNCE_EN`, DB_CYCLES=8: 5-cycle `btn` glitch -> no event. 20-cycle press -> exactly one event.
- `rstn` asserted mid-dwell with `cur_src`=2 -> all outputs 0 at once. After release, source 0 is displayed 2 cycles later.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// ============================================================================
//  Module      : disp_sched_pkg
//  Description : Shared state encoding and defaults for the display scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_OVR    = 2'd2
    } disp_state_t;

    localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/disp_sched_btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Button synchroniser, optional stability filter and rising-
//                edge pulse. Filter enabled by DISP_SCHED_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import disp_sched_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic btn_evt
);

`ifdef DISP_SCHED_DEBOUNCE_EN
    localparam bit c_DB_EN = 1'b1;
`else
    localparam bit c_DB_EN = 1'b0;
`endif

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_evt;
    logic w_level;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (c_DB_EN) begin : g_debounce
            localparam int c_CW = $clog2(DB_CYCLES + 1);
            localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DB_CYCLES - 1);

            logic [c_CW-1:0] r_db_cnt;
            logic            r_db_level;

            // Any return to the accepted level restarts the stability count.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_db_cnt   <= '0;
                    r_db_level <= 1'b0;
                end else if (r_sync2 == r_db_level) begin
                    r_db_cnt   <= '0;
                end else if (r_db_cnt == c_CNT_LAST) begin
                    r_db_cnt   <= '0;
                    r_db_level <= r_sync2;
                end else begin
                    r_db_cnt   <= r_db_cnt + 1'b1;
                end
            end

            assign w_level = r_db_level;
        end else begin : g_passthru
            assign w_level = r_sync2;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level_d <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_evt     <= w_level & ~r_level_d;
        end
    end

    assign btn_evt = r_evt;

endmodule

`default_nettype wire

// File: rtl/disp_sched.sv
// ============================================================================
//  Module      : disp_sched
//  Description : Time-shares the seven-segment driver between NSRC sources
//                (auto rotation, manual button, alert override). Button
//                debounce enabled by DISP_SCHED_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int NSRC      = 3,
    parameter int DWELL     = 5,
    parameter int DIGITS    = 6,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     tick,
    input  logic                     btn,
    input  logic                     auto_en,
    input  logic [NSRC-1:0]          req,
    input  logic [NSRC*DIGITS*8-1:0] src_data,
    input  logic [NSRC*DIGITS-1:0]   src_ctl,
    output logic [DIGITS*8-1:0]      seg_data,
    output logic [DIGITS-1:0]        seg_ctl,
    output logic [$clog2(NSRC)-1:0]  cur_src,
    output logic                     switched
);

    localparam int c_SW = $clog2(NSRC);
    localparam int c_DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_FW = DIGITS * 8;
    localparam logic [c_SW-1:0] c_LAST       = c_SW'(NSRC - 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);

    disp_state_t     r_state, w_state_nxt;
    logic [c_SW-1:0] r_cur_src, w_src_nxt;
    logic [c_SW-1:0] r_saved, w_saved_nxt;
    logic [c_SW-1:0] w_req_idx, w_src_inc;
    logic [c_DW-1:0] r_dwell, w_dwell_nxt;
    logic            r_switched;
    logic            w_req_any;
    logic            w_btn_evt;
    logic [c_FW-1:0]   r_seg_data;
    logic [DIGITS-1:0] r_seg_ctl;
    logic [c_FW-1:0]   w_frame [NSRC];
    logic [DIGITS-1:0] w_ctl   [NSRC];

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rstn    (rstn),
        .btn     (btn),
        .btn_evt (w_btn_evt)
    );

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_frame
            assign w_frame[gi] = src_data[gi*c_FW +: c_FW];
            assign w_ctl[gi]   = src_ctl[gi*DIGITS +: DIGITS];
        end
    endgenerate

    // Lowest-index request wins; scanning downward leaves the lowest hit last.
    always_comb begin
        w_req_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) w_req_idx = c_SW'(i);
        end
    end

    assign w_req_any = |req;
    assign w_src_inc = (r_cur_src == c_LAST) ? '0 : r_cur_src + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_cur_src;
        w_saved_nxt = r_saved;
        w_dwell_nxt = r_dwell;
        case (r_state)
            ST_AUTO, ST_MANUAL: begin
                if (w_req_any) begin
                    w_state_nxt = ST_OVR;
                    w_saved_nxt = r_cur_src;
                    w_src_nxt   = w_req_idx;
                end else begin
                    if (w_btn_evt) begin
                        w_src_nxt   = w_src_inc;
                        w_dwell_nxt = '0;
                    end else if (r_state == ST_AUTO && auto_en && tick) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            w_src_nxt   = w_src_inc;
                            w_dwell_nxt = '0;
                        end else begin
                            w_dwell_nxt = r_dwell + 1'b1;
                        end
                    end
                    if (r_state == ST_AUTO && !auto_en) begin
                        w_state_nxt = ST_MANUAL;
                        w_dwell_nxt = '0;
                    end else if (r_state == ST_MANUAL && auto_en) begin
                        w_state_nxt = ST_AUTO;
                        w_dwell_nxt = '0;
                    end
                end
            end
            ST_OVR: begin
                if (w_req_any) begin
                    w_src_nxt = w_req_idx;
                end else begin
                    w_src_nxt   = r_saved;
                    w_dwell_nxt = '0;
                    w_state_nxt = auto_en ? ST_AUTO : ST_MANUAL;
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
                w_src_nxt   = '0;
                w_dwell_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_MANUAL;
            r_cur_src  <= '0;
            r_saved    <= '0;
            r_dwell    <= '0;
            r_switched <= 1'b0;
            r_seg_data <= '0;
            r_seg_ctl  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_src  <= w_src_nxt;
            r_saved    <= w_saved_nxt;
            r_dwell    <= w_dwell_nxt;
            r_switched <= (w_src_nxt != r_cur_src);
            r_seg_data <= w_frame[r_cur_src];
            r_seg_ctl  <= w_ctl[r_cur_src];
        end
    end

    assign cur_src  = r_cur_src;
    assign switched = r_switched;
    assign seg_data = r_seg_data;
    assign seg_ctl  = r_seg_ctl;

endmodule

`default_nettype wire

// File: tb/tb_disp_sched.sv
// ============================================================================
//  Module      : tb_disp_sched
//  Description : Directed self-checking bench for disp_sched (NSRC=3, DWELL=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_sched;

    localparam int NSRC   = 3;
    localparam int DWELL  = 2;
    localparam int DIGITS = 6;
    localparam int DB     = 8;
`ifdef DISP_SCHED_DEBOUNCE_EN
    localparam int BTN_LAT = 3 + DB;
`else
    localparam int BTN_LAT = 3;
`endif

    logic                     clk;
    logic                     rstn;
    logic                     tick;
    logic                     btn;
    logic                     auto_en;
    logic [NSRC-1:0]          req;
    logic [NSRC*DIGITS*8-1:0] src_data;
    logic [NSRC*DIGITS-1:0]   src_ctl;
    logic [DIGITS*8-1:0]      seg_data;
    logic [DIGITS-1:0]        seg_ctl;
    logic [1:0]               cur_src;
    logic                     switched;

    int n_checks = 0;
    int n_fail   = 0;

    disp_sched #(
        .NSRC      (NSRC),
        .DWELL     (DWELL),
        .DIGITS    (DIGITS),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .tick     (tick),
        .btn      (btn),
        .auto_en  (auto_en),
        .req      (req),
        .src_data (src_data),
        .src_ctl  (src_ctl),
        .seg_data (seg_data),
        .seg_ctl  (seg_ctl),
        .cur_src  (cur_src),
        .switched (switched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       auto_en;
        logic [2:0] req;
        logic [1:0] exp_src;
        logic       exp_sw;
        int         exp_frame;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(logic t, logic a, logic [2:0] r, logic [1:0] s, logic sw, int f);
        vec_t v;
        v.tick = t; v.auto_en = a; v.req = r; v.exp_src = s; v.exp_sw = sw; v.exp_frame = f;
        return v;
    endfunction

    function automatic logic [47:0] frame_of(int i);
        logic [7:0] b;
        b = 8'hA0 + 8'(i);
        return {6{b}};
    endfunction

    function automatic logic [5:0] ctl_of(int i);
        logic [5:0] c;
        c = 6'h20 | (6'h01 << i);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    int e;

    initial begin
        vecs[0]  = mk(1, 1, 3'b000, 0, 0, 0);
        vecs[1]  = mk(0, 1, 3'b000, 0, 0, 0);
        vecs[2]  = mk(1, 1, 3'b000, 1, 1, 0);
        vecs[3]  = mk(0, 1, 3'b000, 1, 0, 1);
        vecs[4]  = mk(1, 1, 3'b000, 1, 0, 1);
        vecs[5]  = mk(1, 1, 3'b000, 2, 1, 1);
        vecs[6]  = mk(1, 1, 3'b000, 2, 0, 2);
        vecs[7]  = mk(1, 1, 3'b000, 0, 1, 2);
        vecs[8]  = mk(0, 1, 3'b000, 0, 0, 0);
        vecs[9]  = mk(1, 1, 3'b000, 0, 0, 0);
        vecs[10] = mk(1, 1, 3'b000, 1, 1, 0);
        vecs[11] = mk(1, 1, 3'b000, 1, 0, 1);
        vecs[12] = mk(0, 1, 3'b110, 1, 0, 1);
        vecs[13] = mk(0, 1, 3'b100, 2, 1, 1);
        vecs[14] = mk(1, 1, 3'b100, 2, 0, 2);
        vecs[15] = mk(0, 1, 3'b000, 1, 1, 2);
        vecs[16] = mk(1, 1, 3'b000, 1, 0, 1);
        vecs[17] = mk(1, 1, 3'b000, 2, 1, 1);
        vecs[18] = mk(0, 0, 3'b000, 2, 0, 2);
        vecs[19] = mk(1, 0, 3'b000, 2, 0, 2);
        vecs[20] = mk(1, 0, 3'b000, 2, 0, 2);
        vecs[21] = mk(0, 0, 3'b001, 0, 1, 2);
        vecs[22] = mk(0, 0, 3'b011, 0, 0, 0);
        vecs[23] = mk(0, 0, 3'b000, 2, 1, 0);
        vecs[24] = mk(0, 1, 3'b000, 2, 0, 2);
        vecs[25] = mk(1, 1, 3'b000, 2, 0, 2);
        vecs[26] = mk(1, 1, 3'b000, 0, 1, 2);

        for (int i = 0; i < NSRC; i++) begin
            src_data[i*48 +: 48] = frame_of(i);
            src_ctl[i*6 +: 6]    = ctl_of(i);
        end
        rstn = 1'b0; tick = 1'b0; btn = 1'b0; auto_en = 1'b1; req = '0;
        step();
        step();
        check("reset cur_src", 64'(cur_src), 64'd0);
        check("reset seg_data", 64'(seg_data), 64'd0);
        check("reset seg_ctl", 64'(seg_ctl), 64'd0);
        check("reset switched", 64'(switched), 64'd0);
        rstn = 1'b1;
        step();

        // Auto rotation, override and mode changes
        for (int k = 0; k < 27; k++) begin
            tick = vecs[k].tick; auto_en = vecs[k].auto_en; req = vecs[k].req;
            step();
            tick = 1'b0;
            check($sformatf("row%0d cur_src", k), 64'(cur_src), 64'(vecs[k].exp_src));
            check($sformatf("row%0d switched", k), 64'(switched), 64'(vecs[k].exp_sw));
            check($sformatf("row%0d seg_data", k), 64'(seg_data), 64'(frame_of(vecs[k].exp_frame)));
            check($sformatf("row%0d seg_ctl", k), 64'(seg_ctl), 64'(ctl_of(vecs[k].exp_frame)));
        end
        req = '0;
        e = 0;

        // Live content pass-through
        src_data[0 +: 48] = 48'h0123_4567_89AB;
        step();
        check("live seg_data", 64'(seg_data), 64'h0123_4567_89AB);
        src_data[0 +: 48] = frame_of(0);

        auto_en = 1'b0;
        step();

`ifdef DISP_SCHED_DEBOUNCE_EN
        btn = 1'b1;
        repeat (5) step();
        btn = 1'b0;
        repeat (20) step();
        check("glitch ignored", 64'(cur_src), 64'(e));
        btn = 1'b1;
        repeat (20) step();
        e = (e + 1) % NSRC;
        check("debounced press", 64'(cur_src), 64'(e));
        btn = 1'b0;
        repeat (20) step();
        check("release no event", 64'(cur_src), 64'(e));
`endif

        // Manual button step
        btn = 1'b1;
        repeat (BTN_LAT) step();
        check("btn before latency", 64'(cur_src), 64'(e));
        step();
        e = (e + 1) % NSRC;
        check("btn advance", 64'(cur_src), 64'(e));
        check("btn switched", 64'(switched), 64'd1);
        btn = 1'b0;
        repeat (BTN_LAT + 4) step();
        check("btn single event", 64'(cur_src), 64'(e));

        // Button and tick together with dwell counter at DWELL-1
        auto_en = 1'b1;
        step();
        tick = 1'b1; step(); tick = 1'b0;
        check("pre-coincide", 64'(cur_src), 64'(e));
        btn = 1'b1;
        repeat (BTN_LAT) step();
        tick = 1'b1; step(); tick = 1'b0;
        e = (e + 1) % NSRC;
        check("coincide +1", 64'(cur_src), 64'(e));
        btn = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        check("coincide cnt cleared", 64'(cur_src), 64'(e));
        tick = 1'b1; step(); tick = 1'b0;
        e = (e + 1) % NSRC;
        check("post-coincide dwell", 64'(cur_src), 64'(e));
        repeat (BTN_LAT + 2) step();

        // Button during override is dropped
        req = 3'b010;
        step();
        check("ovr select", 64'(cur_src), 64'd1);
        btn = 1'b1;
        repeat (BTN_LAT + 1) step();
        check("ovr btn ignored", 64'(cur_src), 64'd1);
        btn = 1'b0;
        repeat (BTN_LAT + 2) step();
        req = '0;
        step();
        check("ovr restore", 64'(cur_src), 64'(e));
        repeat (3) step();
        check("ovr no queued btn", 64'(cur_src), 64'(e));

        // Asynchronous reset mid-dwell on source 2
        for (int n = 0; n < 3 && e != 2; n++) begin
            tick = 1'b1; step(); step(); tick = 1'b0;
            e = (e + 1) % NSRC;
        end
        tick = 1'b1; step(); tick = 1'b0;
        check("pre-reset src", 64'(cur_src), 64'd2);
        #2 rstn = 1'b0;
        #1;
        check("async rst cur_src", 64'(cur_src), 64'd0);
        check("async rst seg_data", 64'(seg_data), 64'd0);
        check("async rst seg_ctl", 64'(seg_ctl), 64'd0);
        check("async rst switched", 64'(switched), 64'd0);
        step();
        rstn = 1'b1;
        step();
        step();
        check("post-rst seg_data", 64'(seg_data), 64'(frame_of(0)));
        check("post-rst seg_ctl", 64'(seg_ctl), 64'(ctl_of(0)));
        check("post-rst cur_src", 64'(cur_src), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
